// File: rtl/cache_defs_pkg.sv
// Shared definitions for the dcache-to-memory bridge: transfer type encodings,
// bridge FSM state encoding and the default cache line size in 32-bit words.
package cache_defs;

   localparam int LINE_WORDS = 4;

   typedef enum logic [2:0] {
      TYPE_BYTE = 3'b000,
      TYPE_HALF = 3'b001,
      TYPE_WORD = 3'b010,
      TYPE_LINE = 3'b100
   } xfer_type_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_WAIT = 3'd2,
      RD_REQ  = 3'd3,
      RD_WAIT = 3'd4
   } state_e;

endpackage

// File: rtl/dcache_wr_line_buf.sv
// Holds the write line latched at request acceptance and selects the word
// for the current memory beat.
module dcache_wr_line_buf
   import cache_defs::*;
#(
   parameter int LINE_WORDS = cache_defs::LINE_WORDS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [32*LINE_WORDS-1:0] line_in,
   input  logic [1:0]              sel,
   output logic [31:0]             word
);

   logic [32*LINE_WORDS-1:0] line_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else if (load) begin
         line_q <= line_in;
      end
   end

   assign word = line_q[32*sel +: 32];

endmodule

// File: rtl/dcache_mem_bridge.sv
// Serialises dcache line/single reads and writes into one-beat-at-a-time memory
// requests. Define DCACHE_BRIDGE_CWF_EN for critical-word-first line reads.
//
// Handshakes: a ram request is taken in the cycle where req and rdy are both
// high; a memory beat request is taken when mem_req_o and mem_gnt_i are both
// high, and its read data returns on a later mem_rvalid_i.
module dcache_mem_bridge
   import cache_defs::*;
#(
   parameter int LINE_WORDS = cache_defs::LINE_WORDS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ram_rd_req_i,
   input  logic [2:0]               ram_rd_type_i,
   input  logic [31:0]              ram_rd_addr_i,
   output logic                     ram_rd_rdy_o,
   output logic [31:0]              ram_rd_data_o,
   output logic                     ram_rd_valid_o,
   output logic                     ram_rd_last_o,
   input  logic                     ram_wr_req_i,
   input  logic [2:0]               ram_wr_type_i,
   input  logic [3:0]               ram_wr_en_i,
   input  logic [31:0]              ram_wr_addr_i,
   input  logic [32*LINE_WORDS-1:0] ram_wr_data_i,
   output logic                     ram_wr_rdy_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [31:0]              mem_addr_o,
   output logic [3:0]               mem_wstrb_o,
   output logic [31:0]              mem_wdata_o,
   input  logic                     mem_gnt_i,
   input  logic                     mem_rvalid_i,
   input  logic [31:0]              mem_rdata_i,
   output state_e                   dbg_state
);

   localparam int CNT_W = $clog2(LINE_WORDS + 1);

   state_e           state, state_n;
   logic [31:0]      addr_q;
   logic [2:0]       type_q;
   logic [3:0]       strb_q;
   logic [1:0]       beat;
   logic [CNT_W-1:0] done_cnt;
   logic [31:0]      rd_data_q;
   logic             rd_valid_q, rd_last_q;

   logic             wr_acc, rd_acc, is_line, last_beat, beat_done;
   logic [CNT_W-1:0] total_beats, done_cnt_inc;
   logic [1:0]       beat_inc, rd_start_beat;
   logic [31:0]      beat_addr, buf_word;

   dcache_wr_line_buf #(.LINE_WORDS(LINE_WORDS)) u_wr_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (wr_acc),
      .line_in (ram_wr_data_i),
      .sel     (beat),
      .word    (buf_word)
   );

   // Beat index wraps around the line; done_cnt alone decides when the burst ends.
   assign is_line      = (type_q == TYPE_LINE);
   assign total_beats  = is_line ? CNT_W'(LINE_WORDS) : CNT_W'(1);
   assign done_cnt_inc = done_cnt + CNT_W'(1);
   assign last_beat    = (done_cnt_inc == total_beats);
   assign beat_inc     = (beat == 2'(LINE_WORDS - 1)) ? 2'd0 : beat + 2'd1;
   assign beat_addr    = is_line ? {addr_q[31:4], beat, 2'b00} : addr_q;
   assign beat_done    = ((state == WR_REQ) && mem_gnt_i) ||
                         ((state == RD_WAIT) && mem_rvalid_i);

`ifdef DCACHE_BRIDGE_CWF_EN
   assign rd_start_beat = (ram_rd_type_i == TYPE_LINE) ? ram_rd_addr_i[3:2] : 2'd0;
`else
   assign rd_start_beat = 2'd0;
`endif

   always_comb begin
      state_n      = state;
      wr_acc       = 1'b0;
      rd_acc       = 1'b0;
      ram_wr_rdy_o = 1'b0;
      ram_rd_rdy_o = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wstrb_o  = '0;
      mem_wdata_o  = '0;
      case (state)
         IDLE: begin
            // A simultaneous read waits here until the write has drained.
            ram_wr_rdy_o = 1'b1;
            ram_rd_rdy_o = !ram_wr_req_i || !rst_n;
            if (ram_wr_req_i) begin
               wr_acc  = 1'b1;
               state_n = WR_REQ;
            end else if (ram_rd_req_i) begin
               rd_acc  = 1'b1;
               state_n = RD_REQ;
            end
         end
         WR_REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = beat_addr;
            mem_wstrb_o = is_line ? 4'hF : strb_q;
            mem_wdata_o = buf_word;
            if (mem_gnt_i) state_n = WR_WAIT;
         end
         WR_WAIT: begin
            state_n = (done_cnt == total_beats) ? IDLE : WR_REQ;
         end
         RD_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = beat_addr;
            if (mem_gnt_i) state_n = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid_i) state_n = last_beat ? IDLE : RD_REQ;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         type_q     <= '0;
         strb_q     <= '0;
         beat       <= '0;
         done_cnt   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state      <= state_n;
         rd_valid_q <= (state == RD_WAIT) && mem_rvalid_i;
         rd_last_q  <= (state == RD_WAIT) && mem_rvalid_i && last_beat;
         if ((state == RD_WAIT) && mem_rvalid_i) rd_data_q <= mem_rdata_i;
         if (wr_acc) begin
            addr_q   <= ram_wr_addr_i;
            type_q   <= ram_wr_type_i;
            strb_q   <= ram_wr_en_i;
            beat     <= 2'd0;
            done_cnt <= '0;
         end else if (rd_acc) begin
            addr_q   <= ram_rd_addr_i;
            type_q   <= ram_rd_type_i;
            strb_q   <= 4'h0;
            beat     <= rd_start_beat;
            done_cnt <= '0;
         end else if (beat_done) begin
            beat     <= beat_inc;
            done_cnt <= done_cnt_inc;
         end
      end
   end

   assign ram_rd_data_o  = rd_data_q;
   assign ram_rd_valid_o = rd_valid_q;
   assign ram_rd_last_o  = rd_last_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge with a one-beat memory responder whose
// read data is the bitwise inverse of the beat address.
module tb_dcache_mem_bridge;
   import cache_defs::*;

   logic         clk;
   logic         rst_n;
   logic         ram_rd_req_i;
   logic [2:0]   ram_rd_type_i;
   logic [31:0]  ram_rd_addr_i;
   logic         ram_rd_rdy_o;
   logic [31:0]  ram_rd_data_o;
   logic         ram_rd_valid_o;
   logic         ram_rd_last_o;
   logic         ram_wr_req_i;
   logic [2:0]   ram_wr_type_i;
   logic [3:0]   ram_wr_en_i;
   logic [31:0]  ram_wr_addr_i;
   logic [127:0] ram_wr_data_i;
   logic         ram_wr_rdy_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [3:0]   mem_wstrb_o;
   logic [31:0]  mem_wdata_o;
   logic         mem_gnt_i;
   logic         mem_rvalid_i;
   logic [31:0]  mem_rdata_i;
   state_e       dbg_state;

   int total = 0;
   int bad   = 0;

   bit          gnt_en = 1'b1;
   bit          spur_rv = 1'b0;
   bit          rd_pend;
   logic [31:0] pend_addr;

   logic [32:0] obs_rd_q[$];   // {last, data}
   logic [67:0] obs_wr_q[$];   // {addr, wstrb, wdata}
   bit          ord_q[$];      // 0: write beat granted, 1: read data returned
   logic [31:0] exp_q[$];

   dcache_mem_bridge dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ram_rd_req_i   (ram_rd_req_i),
      .ram_rd_type_i  (ram_rd_type_i),
      .ram_rd_addr_i  (ram_rd_addr_i),
      .ram_rd_rdy_o   (ram_rd_rdy_o),
      .ram_rd_data_o  (ram_rd_data_o),
      .ram_rd_valid_o (ram_rd_valid_o),
      .ram_rd_last_o  (ram_rd_last_o),
      .ram_wr_req_i   (ram_wr_req_i),
      .ram_wr_type_i  (ram_wr_type_i),
      .ram_wr_en_i    (ram_wr_en_i),
      .ram_wr_addr_i  (ram_wr_addr_i),
      .ram_wr_data_i  (ram_wr_data_i),
      .ram_wr_rdy_o   (ram_wr_rdy_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wstrb_o    (mem_wstrb_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .dbg_state      (dbg_state)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: grants immediately, returns read data one cycle later.
   initial begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      rd_pend      = 1'b0;
      pend_addr    = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid_i = rd_pend || spur_rv;
         mem_rdata_i  = rd_pend ? ~pend_addr : 32'h1234_5678;
         rd_pend      = 1'b0;
         if (mem_req_o && gnt_en) begin
            mem_gnt_i = 1'b1;
            if (!mem_we_o) begin
               rd_pend   = 1'b1;
               pend_addr = mem_addr_o;
            end
         end else begin
            mem_gnt_i = 1'b0;
         end
      end
   end

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (ram_rd_valid_o) begin
            obs_rd_q.push_back({ram_rd_last_o, ram_rd_data_o});
            ord_q.push_back(1'b1);
         end
         if (mem_req_o && mem_we_o && mem_gnt_i) begin
            obs_wr_q.push_back({mem_addr_o, mem_wstrb_o, mem_wdata_o});
            ord_q.push_back(1'b0);
         end
      end
   end

   // Driver tasks
   task automatic drive_read(input logic [2:0] t, input logic [31:0] a, output bit ok);
      ok = 1'b0;
      @(posedge clk); #1;
      ram_rd_req_i  = 1'b1;
      ram_rd_type_i = t;
      ram_rd_addr_i = a;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ram_rd_rdy_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      ram_rd_req_i = 1'b0;
   endtask

   task automatic drive_write(input logic [2:0] t, input logic [3:0] en, input logic [31:0] a,
                              input logic [127:0] d, output bit ok);
      ok = 1'b0;
      @(posedge clk); #1;
      ram_wr_req_i  = 1'b1;
      ram_wr_type_i = t;
      ram_wr_en_i   = en;
      ram_wr_addr_i = a;
      ram_wr_data_i = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ram_wr_rdy_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      ram_wr_req_i = 1'b0;
   endtask

   task automatic wait_rd(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (obs_rd_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_wr(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (obs_wr_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic clear_obs();
      obs_rd_q.delete();
      obs_wr_q.delete();
      ord_q.delete();
      exp_q.delete();
   endtask

   // Tests
   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
      total++; if (ram_wr_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_wr_rdy got=%b exp=1", ram_wr_rdy_o); end
      total++; if (ram_rd_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_rd_rdy got=%b exp=1", ram_rd_rdy_o); end
      total++; if ({mem_req_o, mem_we_o, ram_rd_valid_o, ram_rd_last_o} !== 4'b0000) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_req_o, mem_we_o, ram_rd_valid_o, ram_rd_last_o}); end
      total++; if ({mem_addr_o, mem_wstrb_o, mem_wdata_o, ram_rd_data_o} !== 100'd0) begin
         bad++; $display("FAIL reset_data got=%h exp=0", {mem_addr_o, mem_wstrb_o, mem_wdata_o, ram_rd_data_o}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_line_read();
      bit ok;
      logic [32:0] got;
      logic [31:0] exp;
      clear_obs();
`ifdef DCACHE_BRIDGE_CWF_EN
      exp_q = '{32'hEFFF_FFD7, 32'hEFFF_FFD3, 32'hEFFF_FFDF, 32'hEFFF_FFDB};
`else
      exp_q = '{32'hEFFF_FFDF, 32'hEFFF_FFDB, 32'hEFFF_FFD7, 32'hEFFF_FFD3};
`endif
      drive_read(3'b100, 32'h1000_0028, ok);
      total++; if (!ok) begin bad++; $display("FAIL line_rd_accept got=timeout exp=accept"); end
      wait_rd(4, ok);
      total++; if (!ok) begin bad++; $display("FAIL line_rd_beats got=%0d exp=4", obs_rd_q.size()); end
      repeat (4) @(negedge clk);
      total++; if (obs_rd_q.size() != 4) begin bad++; $display("FAIL line_rd_count got=%0d exp=4", obs_rd_q.size()); end
      for (int i = 0; i < 4; i++) begin
         if (obs_rd_q.size() == 0) break;
         got = obs_rd_q.pop_front();
         exp = exp_q.pop_front();
         total++; if (got[31:0] !== exp) begin bad++; $display("FAIL line_rd_data%0d got=%h exp=%h", i, got[31:0], exp); end
         total++; if (got[32] !== 1'(i == 3)) begin bad++; $display("FAIL line_rd_last%0d got=%b exp=%b", i, got[32], i == 3); end
      end
      total++; if (dbg_state !== IDLE || ram_rd_rdy_o !== 1'b1) begin
         bad++; $display("FAIL line_rd_idle got=%0d/%b exp=%0d/1", dbg_state, ram_rd_rdy_o, IDLE); end
   endtask

   task automatic test_single_read();
      bit ok;
      logic [32:0] got;
      clear_obs();
      drive_read(3'b000, 32'h0000_0077, ok);
      wait_rd(1, ok);
      repeat (3) @(negedge clk);
      total++; if (obs_rd_q.size() != 1) begin bad++; $display("FAIL byte_rd_count got=%0d exp=1", obs_rd_q.size()); end
      if (obs_rd_q.size() > 0) begin
         got = obs_rd_q.pop_front();
         total++; if (got !== {1'b1, 32'hFFFF_FF88}) begin bad++; $display("FAIL byte_rd_beat got=%h exp=1ffffff88", got); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [67:0] w;
      logic [32:0] got;
      logic [31:0] exp_addr[4];
      logic [31:0] exp_rd[4];
      clear_obs();
      exp_addr = '{32'h2000_0010, 32'h2000_0014, 32'h2000_0018, 32'h2000_001C};
      exp_rd   = '{32'hCFFF_FFFF, 32'hCFFF_FFFB, 32'hCFFF_FFF7, 32'hCFFF_FFF3};
      @(posedge clk); #1;
      ram_wr_req_i  = 1'b1;
      ram_wr_type_i = 3'b100;
      ram_wr_en_i   = 4'h0;
      ram_wr_addr_i = 32'h2000_0010;
      ram_wr_data_i = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
      ram_rd_req_i  = 1'b1;
      ram_rd_type_i = 3'b100;
      ram_rd_addr_i = 32'h3000_0000;
      @(negedge clk);
      total++; if ({ram_wr_rdy_o, ram_rd_rdy_o} !== 2'b10) begin
         bad++; $display("FAIL b2b_rdy got=%b exp=10", {ram_wr_rdy_o, ram_rd_rdy_o}); end
      @(posedge clk); #1;
      ram_wr_req_i = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ram_rd_rdy_o) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      ram_rd_req_i = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL b2b_rd_accept got=timeout exp=accept"); end
      wait_rd(4, ok);
      repeat (3) @(negedge clk);
      total++; if (obs_wr_q.size() != 4 || obs_rd_q.size() != 4) begin
         bad++; $display("FAIL b2b_counts got=%0d/%0d exp=4/4", obs_wr_q.size(), obs_rd_q.size()); end
      for (int i = 0; i < 8 && i < ord_q.size(); i++) begin
         total++; if (ord_q[i] !== 1'(i >= 4)) begin bad++; $display("FAIL b2b_order%0d got=%b exp=%b", i, ord_q[i], i >= 4); end
      end
      for (int i = 0; i < 4; i++) begin
         if (obs_wr_q.size() == 0) break;
         w = obs_wr_q.pop_front();
         total++; if (w !== {exp_addr[i], 4'hF, 32'h1111_0000 + 32'(i)}) begin
            bad++; $display("FAIL b2b_wr%0d got=%h exp=%h", i, w, {exp_addr[i], 4'hF, 32'h1111_0000 + 32'(i)}); end
      end
      for (int i = 0; i < 4; i++) begin
         if (obs_rd_q.size() == 0) break;
         got = obs_rd_q.pop_front();
         total++; if (got !== {1'(i == 3), exp_rd[i]}) begin
            bad++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, got, {1'(i == 3), exp_rd[i]}); end
      end
   endtask

   task automatic test_word_write();
      bit ok;
      logic [67:0] w;
      clear_obs();
      drive_write(3'b010, 4'b0110, 32'h0000_0044, {96'h0, 32'hCAFE_F00D}, ok);
      wait_wr(1, ok);
      repeat (5) @(negedge clk);
      total++; if (obs_wr_q.size() != 1 || obs_rd_q.size() != 0) begin
         bad++; $display("FAIL word_wr_beats got=%0d/%0d exp=1/0", obs_wr_q.size(), obs_rd_q.size()); end
      if (obs_wr_q.size() > 0) begin
         w = obs_wr_q.pop_front();
         total++; if (w !== {32'h0000_0044, 4'b0110, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL word_wr_beat got=%h exp=%h", w, {32'h0000_0044, 4'b0110, 32'hCAFE_F00D}); end
      end
   endtask

   task automatic test_gnt_stall();
      bit ok;
      logic [67:0] w;
      clear_obs();
      gnt_en = 1'b0;
      drive_write(3'b100, 4'h0, 32'h5000_0000,
                  {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}, ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if ({mem_req_o, mem_addr_o, mem_wdata_o, ram_wr_rdy_o, ram_rd_rdy_o} !==
                      {1'b1, 32'h5000_0000, 32'hDEAD_0000, 2'b00}) begin
            bad++; $display("FAIL stall_hold%0d got=%b/%h/%h/%b%b exp=1/50000000/dead0000/00",
                            i, mem_req_o, mem_addr_o, mem_wdata_o, ram_wr_rdy_o, ram_rd_rdy_o); end
      end
      @(posedge clk); #1;
      gnt_en = 1'b1;
      wait_wr(4, ok);
      repeat (3) @(negedge clk);
      total++; if (obs_wr_q.size() != 4) begin bad++; $display("FAIL stall_beats got=%0d exp=4", obs_wr_q.size()); end
      if (obs_wr_q.size() == 4) begin
         w = obs_wr_q[3];
         total++; if (w !== {32'h5000_000C, 4'hF, 32'hDEAD_0003}) begin
            bad++; $display("FAIL stall_last_beat got=%h exp=%h", w, {32'h5000_000C, 4'hF, 32'hDEAD_0003}); end
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      clear_obs();
      drive_read(3'b100, 32'h6000_0000, ok);
      wait_rd(2, ok);
      rst_n = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL midrst_two_beats got=%0d exp=2", obs_rd_q.size()); end
      if (obs_rd_q.size() >= 2) begin
         total++; if (obs_rd_q[1] !== {1'b0, 32'h9FFF_FFFB}) begin
            bad++; $display("FAIL midrst_beat1 got=%h exp=09ffffffb", obs_rd_q[1]); end
      end
      obs_rd_q.delete();
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      total++; if (obs_rd_q.size() != 0) begin bad++; $display("FAIL midrst_valids got=%0d exp=0", obs_rd_q.size()); end
      total++; if (dbg_state !== IDLE || {ram_wr_rdy_o, ram_rd_rdy_o} !== 2'b11 || mem_req_o !== 1'b0) begin
         bad++; $display("FAIL midrst_idle got=%0d/%b%b/%b exp=%0d/11/0", dbg_state, ram_wr_rdy_o, ram_rd_rdy_o, mem_req_o, IDLE); end
   endtask

   task automatic test_spurious_rvalid();
      clear_obs();
      @(posedge clk); #1;
      spur_rv = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      spur_rv = 1'b0;
      repeat (4) @(negedge clk);
      total++; if (obs_rd_q.size() != 0) begin bad++; $display("FAIL spurious_valid got=%0d exp=0", obs_rd_q.size()); end
      total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL spurious_state got=%0d exp=%0d", dbg_state, IDLE); end
   endtask

   initial begin
      rst_n         = 1'b0;
      ram_rd_req_i  = 1'b0;
      ram_rd_type_i = '0;
      ram_rd_addr_i = '0;
      ram_wr_req_i  = 1'b0;
      ram_wr_type_i = '0;
      ram_wr_en_i   = '0;
      ram_wr_addr_i = '0;
      ram_wr_data_i = '0;
      test_reset();
      test_line_read();
      test_single_read();
      test_back_to_back();
      test_word_write();
      test_gnt_stall();
      test_reset_mid_burst();
      test_spurious_rvalid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
